// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: instruction-fetch sequencer for a synchronous-read program ROM.
// Streams sequential addresses into the ROM, tracks reads in flight, buffers the
// returned bytes (tagged with their address) in a small FIFO and hands them to
// the decoder over valid/ready. A redirect squashes everything older than itself.
module rom_fetch_ctrl #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rom_ad,
    output logic                  rom_ce,
    output logic                  rom_oce,
    output logic                  rom_reset,
    input  logic [DATA_WIDTH-1:0] rom_dout
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    // Fetch pointer and last address driven to the ROM
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] rom_ad_q, rom_ad_d;
    logic                  rom_oce_q;
    logic                  rom_reset_q;

    // In-flight tracker: stage i holds a read issued i+1 cycles ago
    logic [READ_LATENCY-1:0] stg_vld_q, stg_vld_d;
    logic [ADDR_WIDTH-1:0]   stg_pc_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   stg_pc_d [READ_LATENCY];

    // Byte FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [CNT_W-1:0] inflight_cnt_s;
    logic [SUM_W-1:0] credit_used_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_nempty_s;

    assign fifo_nempty_s = (count_q != {CNT_W{1'b0}});
    assign push_s        = stg_vld_q[READ_LATENCY-1];
    assign pop_s         = fifo_nempty_s & out_ready;

    // Issue decision: a new read only when every byte it could produce has a FIFO slot reserved
    always_comb begin
        inflight_cnt_s = {CNT_W{1'b0}};
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt_s = inflight_cnt_s + CNT_W'(stg_vld_q[i]);
        end
        credit_used_s = SUM_W'(inflight_cnt_s) + SUM_W'(count_q);
        issue_s = ~RESET & en & ~redirect_valid & (credit_used_s < SUM_W'(FIFO_DEPTH));
    end

    // Next fetch pointer, held ROM address and in-flight shift; a redirect kills all tracked reads
    always_comb begin
        pc_d      = pc_q;
        rom_ad_d  = rom_ad_q;
        stg_vld_d = stg_vld_q;
        stg_pc_d  = stg_pc_q;
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            stg_vld_d = {READ_LATENCY{1'b0}};
        end else begin
            stg_vld_d[0] = issue_s;
            stg_pc_d[0]  = pc_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stg_vld_d[i] = stg_vld_q[i-1];
                stg_pc_d[i]  = stg_pc_q[i-1];
            end
            if (issue_s) begin
                pc_d     = pc_q + ADDR_WIDTH'(1);
                rom_ad_d = pc_q;
            end else begin
                pc_d     = pc_q;
                rom_ad_d = rom_ad_q;
            end
        end
    end

    // FIFO pointer/occupancy update; a redirect empties the buffer (a same-cycle pop is simply absorbed)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q      <= RESET_VECTOR;
            rom_ad_q  <= {ADDR_WIDTH{1'b0}};
            stg_vld_q <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                stg_pc_q[i] <= {ADDR_WIDTH{1'b0}};
            end
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            rom_oce_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            rom_ad_q  <= rom_ad_d;
            stg_vld_q <= stg_vld_d;
            stg_pc_q  <= stg_pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rom_oce_q <= (READ_LATENCY == 2) ? 1'b1 : 1'b0;
        end
    end

    // FIFO storage: capture the ROM byte with its address when the oldest tracked read matures
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= {DATA_WIDTH{1'b0}};
                mem_pc_q[i]   <= {ADDR_WIDTH{1'b0}};
            end
        end else if (push_s && !redirect_valid) begin
            mem_data_q[wr_ptr_q] <= rom_dout;
            mem_pc_q[wr_ptr_q]   <= stg_pc_q[READ_LATENCY-1];
        end
    end

    // ROM output reset follows RESET one cycle later
    always_ff @(posedge CLK) begin
        rom_reset_q <= RESET;
    end

    assign rom_ce    = issue_s;
    assign rom_ad    = issue_s ? pc_q : rom_ad_q;
    assign rom_oce   = rom_oce_q;
    assign rom_reset = rom_reset_q;
    assign out_valid = fifo_nempty_s;
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_pc    = mem_pc_q[rd_ptr_q];
    assign busy      = (|stg_vld_q) | fifo_nempty_s;

endmodule
